// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass and a post-reset clear sequencer.
// Read latency 1 cycle; ready stays low while the array is cleared one entry per edge.
module regfile_mp #(
  parameter  int WIDTH    = 32,
  parameter  int NREGS    = 32,
  parameter  int NREAD    = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NREAD-1:0]       ren,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic                   ready
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic                     ready_q, ready_d;
  logic [NREAD*WIDTH-1:0]   rdata_q, rdata_d;

  logic [WIDTH-1:0]         mem_q [NREGS];
  logic                     mem_we;
  logic [AW-1:0]            mem_waddr;
  logic [WIDTH-1:0]         mem_wdata;
  logic                     wr_ok;
  logic [AW-1:0]            ra;

  // A write to entry 0 is dropped when that entry is hardwired to zero.
  assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ready_d   = ready_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = '0;
    ra        = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        rdata_d   = '0;
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end else begin
          idx_d = idx_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        mem_we    = wr_ok;
        mem_waddr = waddr;
        mem_wdata = wdata;
        for (int p = 0; p < NREAD; p++) begin
          ra = raddr[p*AW +: AW];
          if (ren[p]) begin
            if ((ZERO_REG != 0) && (ra == '0))
              rdata_d[p*WIDTH +: WIDTH] = '0;
            else if (wr_ok && (waddr == ra))
              rdata_d[p*WIDTH +: WIDTH] = wdata;
            else
              rdata_d[p*WIDTH +: WIDTH] = mem_q[ra];
          end
        end
      end
    endcase
    // The reset edge leaves the array untouched.
    if (!rst_n)
      mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[mem_waddr] <= mem_wdata;
  end

  assign rdata = rdata_q;
  assign ready = ready_q;

endmodule
